// File: rtl/upload_arbiter_if.sv
// upload_arbiter_if: upload signals between protocol handlers, the arbiter and command_processor
//   src_upload_req/valid/data/source : per-channel session request, byte strobe, byte, source code
//   src_upload_ready                 : per-channel FIFO not full
//   merged_upload_req/valid/data/source/ready : single upload path toward command_processor
//   overflow_flag                    : per-channel sticky byte-dropped flag
//   master = handler/command_processor side, slave = arbiter side
interface upload_arbiter_if #(parameter int NUM_CH = 2);
  logic [NUM_CH-1:0] src_upload_req, src_upload_valid, src_upload_ready, overflow_flag;
  logic [8*NUM_CH-1:0] src_upload_data, src_upload_source;
  logic merged_upload_req, merged_upload_valid, merged_upload_ready;
  logic [7:0] merged_upload_data, merged_upload_source;
  modport master (
    output src_upload_req, src_upload_valid, src_upload_data, src_upload_source, merged_upload_ready,
    input  src_upload_ready, merged_upload_req, merged_upload_valid, merged_upload_data,
           merged_upload_source, overflow_flag
  );
  modport slave (
    input  src_upload_req, src_upload_valid, src_upload_data, src_upload_source, merged_upload_ready,
    output src_upload_ready, merged_upload_req, merged_upload_valid, merged_upload_data,
           merged_upload_source, overflow_flag
  );
endinterface

// File: rtl/upload_arbiter.sv
// upload_arbiter: per-channel byte FIFOs drained round-robin, one channel per upload session
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : upload_arbiter_if.slave (handler inputs, command_processor output path, overflow flags)
module upload_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int FIFO_AW      = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  upload_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT   = 2'd1;
  localparam logic [1:0] ARB_DRAIN   = 2'd2;
  localparam logic [1:0] ARB_RELEASE = 2'd3;
  logic [NUM_CH-1:0] push, pop, nz, rdy, ovf;
  logic [16*NUM_CH-1:0] head;
  logic [1:0] state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic found;
  logic [TW-1:0] tmo_q, tmo_d;
  logic req_q, req_d, valid_q;
  logic [15:0] out_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [15:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0] cnt_q;
    logic ovf_q;
    assign nz[i] = cnt_q != '0;
    // ready comes from the registered count, so a push while full is dropped even if a pop frees a slot
    assign rdy[i] = cnt_q != FULL;
    assign push[i] = bus.src_upload_valid[i] && rdy[i];
    assign pop[i] = state_q == ARB_DRAIN && grant_q == GW'(i) && nz[i] && bus.merged_upload_ready;
    assign head[16*i +: 16] = mem_q[rd_q];
    assign ovf[i] = ovf_q;
    always_ff @(posedge clk)
      if (push[i]) mem_q[wr_q] <= {bus.src_upload_source[8*i +: 8], bus.src_upload_data[8*i +: 8]};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push[i]) wr_q <= wr_q + 1'b1;
        if (pop[i]) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + {{FIFO_AW{1'b0}}, push[i]} - {{FIFO_AW{1'b0}}, pop[i]};
        if (bus.src_upload_valid[i] && !rdy[i]) ovf_q <= 1'b1;
      end
  end
  // descending scan so the nearest channel after last_q wins
  always_comb begin
    pick = last_q;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_CH);
      if (nz[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    tmo_d = tmo_q;
    req_d = req_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = found ? pick : grant_q;
        state_d = found ? ARB_GRANT : ARB_IDLE;
      end
      ARB_GRANT: begin
        req_d = 1'b1;
        tmo_d = '0;
        state_d = ARB_DRAIN;
      end
      ARB_DRAIN:
        if (|pop) tmo_d = '0;
        else if (!nz[grant_q]) begin
          if (!bus.src_upload_req[grant_q] || tmo_q == TW'(HOLD_TIMEOUT - 1)) state_d = ARB_RELEASE;
          else tmo_d = tmo_q + 1'b1;
        end
      default: begin
        req_d = 1'b0;
        last_d = grant_q;
        state_d = ARB_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
      tmo_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      valid_q <= |pop;
      if (|pop) out_q <= head[16*grant_q +: 16];
    end
  assign bus.src_upload_ready = rdy;
  assign bus.overflow_flag = ovf;
  assign bus.merged_upload_req = req_q;
  assign bus.merged_upload_valid = valid_q;
  assign bus.merged_upload_data = out_q[7:0];
  assign bus.merged_upload_source = out_q[15:8];
endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: scoreboard bench for upload_arbiter
module tb_upload_arbiter;
  localparam int NUM_CH = 2;
  localparam int FIFO_AW = 4;
  localparam int HOLD_TIMEOUT = 1024;
  localparam logic [7:0] S0 = 8'h06;
  localparam logic [7:0] S1 = 8'h09;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  upload_arbiter_if #(.NUM_CH(NUM_CH)) bus ();
  upload_arbiter #(.NUM_CH(NUM_CH), .FIFO_AW(FIFO_AW), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int checks = 0, errors = 0, cyc = 0, vcnt = 0, low_cnt = 0, last_v_cyc = 0, fall_cyc = 0;
  int vcyc [$];
  logic [15:0] exp_q [$];
  logic prev_req = 1'b0, seen = 1'b0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst_n) begin
      prev_req <= 1'b0;
      seen <= 1'b0;
      low_cnt <= 0;
    end else begin
      if (bus.merged_upload_valid) begin
        check("valid_with_req", bus.merged_upload_req, 1);
        if (exp_q.size() == 0) check("unexpected_byte", {bus.merged_upload_source, bus.merged_upload_data}, 32'hFFFF_FFFF);
        else check("byte", {bus.merged_upload_source, bus.merged_upload_data}, exp_q.pop_front());
        vcnt <= vcnt + 1;
        last_v_cyc <= cyc;
        vcyc.push_back(cyc);
      end
      if (bus.merged_upload_req && !prev_req && seen) check("req_gap_ge2", low_cnt >= 2, 1);
      if (!bus.merged_upload_req && prev_req) fall_cyc <= cyc;
      low_cnt <= bus.merged_upload_req ? 0 : low_cnt + 1;
      seen <= seen | bus.merged_upload_req;
      prev_req <= bus.merged_upload_req;
    end
  task automatic push(input int ch, input logic [7:0] d, input logic [7:0] s, input bit keep);
    @(negedge clk);
    bus.src_upload_valid[ch] = 1'b1;
    bus.src_upload_data[8*ch +: 8] = d;
    bus.src_upload_source[8*ch +: 8] = s;
    if (keep) exp_q.push_back({s, d});
    @(negedge clk);
    bus.src_upload_valid = '0;
  endtask
  task automatic push_both(input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    bus.src_upload_valid = 2'b11;
    bus.src_upload_data = {d1, d0};
    bus.src_upload_source = {S1, S0};
    @(negedge clk);
    bus.src_upload_valid = '0;
  endtask
  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (n < max && (exp_q.size() != 0 || bus.merged_upload_req));
    check(tag, exp_q.size() == 0 && !bus.merged_upload_req, 1);
  endtask
  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (n < max && !bus.merged_upload_req) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, bus.merged_upload_req, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int b;
    bus.src_upload_req = '0;
    bus.src_upload_valid = '0;
    bus.src_upload_data = '0;
    bus.src_upload_source = '0;
    bus.merged_upload_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_src_ready", bus.src_upload_ready, 2'b11);
    check("rst_req", bus.merged_upload_req, 0);
    check("rst_valid", bus.merged_upload_valid, 0);
    check("rst_data", bus.merged_upload_data, 0);
    check("rst_source", bus.merged_upload_source, 0);
    check("rst_ovf", bus.overflow_flag, 0);
    rst_n = 1'b1;
    // single-channel session
    bus.merged_upload_ready = 1'b1;
    bus.src_upload_req[0] = 1'b1;
    push(0, 8'h11, S0, 1);
    push(0, 8'h22, S0, 1);
    push(0, 8'h33, S0, 1);
    bus.src_upload_req[0] = 1'b0;
    wait_drain("t1_drain", 100);
    check("t1_req_fall_delay", fall_cyc - last_v_cyc, 2);
    // two channels from reset: ch0 first, then round-robin gives ch1 first
    do_reset();
    push_both(8'hA0, 8'hB0);
    push_both(8'hA1, 8'hB1);
    exp_q.push_back({S0, 8'hA0});
    exp_q.push_back({S0, 8'hA1});
    exp_q.push_back({S1, 8'hB0});
    exp_q.push_back({S1, 8'hB1});
    wait_drain("t2_round1", 100);
    push(0, 8'h5A, S0, 1);
    wait_drain("t2_ch0_only", 100);
    push_both(8'hA2, 8'hB2);
    push_both(8'hA3, 8'hB3);
    exp_q.push_back({S1, 8'hB2});
    exp_q.push_back({S1, 8'hB3});
    exp_q.push_back({S0, 8'hA2});
    exp_q.push_back({S0, 8'hA3});
    wait_drain("t2_round2", 100);
    // ch0 holds the grant with req high and no data until the timeout
    b = vcnt;
    bus.src_upload_req[0] = 1'b1;
    push(0, 8'h77, S0, 1);
    wait_req("t4_req", 20);
    push(1, 8'hC0, S1, 1);
    push(1, 8'hC1, S1, 1);
    wait_drain("t4_drain", 3 * HOLD_TIMEOUT);
    bus.src_upload_req[0] = 1'b0;
    check("t4_hold_window", (vcyc[b+1] - vcyc[b]) >= HOLD_TIMEOUT && (vcyc[b+1] - vcyc[b]) <= HOLD_TIMEOUT + 8, 1);
    check("t4_ovf", bus.overflow_flag, 0);
    // ch1 overflow while command_processor stalls
    bus.merged_upload_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 16) check("t3_src_ready_low", bus.src_upload_ready[1], 0);
      push(1, 8'h40 + 8'(i), S1, i < 16);
    end
    check("t3_ovf", bus.overflow_flag, 2'b10);
    bus.merged_upload_ready = 1'b1;
    b = vcnt;
    wait_drain("t3_drain", 200);
    check("t3_count", vcnt - b, 16);
    // ch0 full: a push in the same cycle as a pop is still dropped
    bus.merged_upload_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(0, 8'h80 + 8'(i), S0, 1);
    wait_req("t5_req", 20);
    check("t5_full", bus.src_upload_ready[0], 0);
    b = vcnt;
    @(negedge clk);
    bus.merged_upload_ready = 1'b1;
    bus.src_upload_valid[0] = 1'b1;
    bus.src_upload_data[7:0] = 8'hEE;
    @(negedge clk);
    bus.src_upload_valid = '0;
    bus.merged_upload_ready = 1'b0;
    #1;
    check("t5_ovf", bus.overflow_flag, 2'b11);
    check("t5_count_15", bus.src_upload_ready[0], 1);
    bus.merged_upload_ready = 1'b1;
    wait_drain("t5_drain", 200);
    check("t5_count", vcnt - b, 16);
    // reset in the middle of a session
    bus.merged_upload_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 8'hD0 + 8'(i), S0, 1);
    wait_req("t6_req", 20);
    bus.merged_upload_ready = 1'b1;
    b = vcnt;
    for (int n = 0; n < 50 && vcnt < b + 2; n++) begin
      @(negedge clk);
      #1;
    end
    check("t6_two_bytes", vcnt - b, 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_req", bus.merged_upload_req, 0);
    check("t6_valid", bus.merged_upload_valid, 0);
    check("t6_data", bus.merged_upload_data, 0);
    check("t6_source", bus.merged_upload_source, 0);
    check("t6_src_ready", bus.src_upload_ready, 2'b11);
    check("t6_ovf", bus.overflow_flag, 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_valid_in_rst", bus.merged_upload_valid, 0);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("t6_no_more_bytes", vcnt - b, 2);
    check("t6_idle_req", bus.merged_upload_req, 0);
    check("t6_empty", bus.src_upload_ready, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
